// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate register: one 1-bit step per clock under a start/busy/done
// handshake, with carry, sticky-lost and zero status flags.
module shift_unit_seq #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             carry,
   output logic             lost,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [AMT_W-1:0] AMT_ZERO = AMT_W'(0);
   localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

   state_t           state_r;
   logic [2:0]       op_r;
   logic [AMT_W-1:0] cnt_r;

   logic [WIDTH-1:0] step_q_s;
   logic             step_out_s;
   logic             step_flag_s;   // step updates carry
   logic             step_lose_s;   // step may discard a bit (non-rotate)

   // One-bit step result for the latched mode
   always_comb begin
      step_q_s    = q;
      step_out_s  = 1'b0;
      step_flag_s = 1'b0;
      step_lose_s = 1'b0;
      case (op_r)
         3'b000: begin
            step_q_s    = {q[WIDTH-2:0], 1'b0};
            step_out_s  = q[WIDTH-1];
            step_flag_s = 1'b1;
            step_lose_s = 1'b1;
         end
         3'b001: begin
            step_q_s    = {1'b0, q[WIDTH-1:1]};
            step_out_s  = q[0];
            step_flag_s = 1'b1;
            step_lose_s = 1'b1;
         end
         3'b010: begin
            step_q_s    = {q[WIDTH-1], q[WIDTH-1:1]};
            step_out_s  = q[0];
            step_flag_s = 1'b1;
            step_lose_s = 1'b1;
         end
         3'b011: begin
            step_q_s    = {q[WIDTH-2:0], q[WIDTH-1]};
            step_out_s  = q[WIDTH-1];
            step_flag_s = 1'b1;
            step_lose_s = 1'b0;
         end
         3'b100: begin
            step_q_s    = {q[0], q[WIDTH-1:1]};
            step_out_s  = q[0];
            step_flag_s = 1'b1;
            step_lose_s = 1'b0;
         end
         3'b101: begin
            step_q_s    = {q[WIDTH-2:0], serial_in};
            step_out_s  = q[WIDTH-1];
            step_flag_s = 1'b1;
            step_lose_s = 1'b1;
         end
         3'b110: begin
            step_q_s    = {serial_in, q[WIDTH-1:1]};
            step_out_s  = q[0];
            step_flag_s = 1'b1;
            step_lose_s = 1'b1;
         end
         default: begin
            // reserved mode: register and flags hold, handshake still runs
            step_q_s    = q;
            step_out_s  = 1'b0;
            step_flag_s = 1'b0;
            step_lose_s = 1'b0;
         end
      endcase
   end

   // Control FSM, data register and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         op_r    <= 3'b000;
         cnt_r   <= AMT_ZERO;
         q       <= '0;
         carry   <= 1'b0;
         lost    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (load) begin
                  q       <= din;
                  carry   <= 1'b0;
                  lost    <= 1'b0;
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else if (start) begin
                  op_r  <= op;
                  cnt_r <= amount;
                  carry <= 1'b0;
                  lost  <= 1'b0;
                  if (amount == AMT_ZERO) begin
                     state_r <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state_r <= SHIFT;
                     busy    <= 1'b1;
                     done    <= 1'b0;
                  end
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            SHIFT: begin
               q     <= step_q_s;
               cnt_r <= cnt_r - AMT_ONE;
               if (step_flag_s) begin
                  carry <= step_out_s;
               end else begin
                  carry <= carry;
               end
               if (step_lose_s) begin
                  lost <= lost | step_out_s;
               end else begin
                  lost <= lost;
               end
               if (cnt_r == AMT_ONE) begin
                  state_r <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  state_r <= SHIFT;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   assign zero = (q == '0);

endmodule
